// File: rtl/wb_slave_decoder_n_pkg.sv
// Shared types and default memory map for the Wishbone slave decoder.
package wb_slave_decoder_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } wb_state_e;

  // Default SoC map: slave0 BRAM, slave1 BROM, slave2 SDRAM, slave3 MMAP
  localparam logic [31:0] MAP_BRAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MAP_BRAM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] MAP_BROM_BASE  = 32'h0001_0000;
  localparam logic [31:0] MAP_BROM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] MAP_SDRAM_BASE = 32'h8000_0000;
  localparam logic [31:0] MAP_SDRAM_MASK = 32'hFF00_0000;
  localparam logic [31:0] MAP_MMAP_BASE  = 32'h4000_0000;
  localparam logic [31:0] MAP_MMAP_MASK  = 32'hFF80_0000;

  // Packed with slave i at [i*32 +: 32], so the highest index sits leftmost
  localparam logic [127:0] DEF_SLV_BASE =
    {MAP_MMAP_BASE, MAP_SDRAM_BASE, MAP_BROM_BASE, MAP_BRAM_BASE};
  localparam logic [127:0] DEF_SLV_MASK =
    {MAP_MMAP_MASK, MAP_SDRAM_MASK, MAP_BROM_MASK, MAP_BRAM_MASK};

endpackage

// File: rtl/wb_slave_decoder_n_addr_decode.sv
// Combinational base/mask matcher; the lowest matching slave index wins.
module wb_slave_decoder_n_addr_decode #(
  parameter int                 NSLV     = 4,
  parameter int                 AW       = 32,
  parameter int                 IW       = 2,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0
) (
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  // Walk from the top index down so a lower-index match overrides a higher one
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_slave_decoder_n.sv
// Single-master pipelined Wishbone decoder: routes one outstanding transfer to
// the slave whose window matches, errors unmapped or timed-out accesses and
// keeps the last faulting address for software.
//
// state | meaning
// IDLE  | no transfer in flight; a cyc&stb request is latched and decoded
// REQ   | selected slave sees cyc+stb until it stops stalling
// WAIT  | slave took the request (stb low, cyc high); waiting for its ack
// ERR   | one-cycle error response for an unmapped or timed-out access
module wb_slave_decoder_n
  import wb_slave_decoder_n_pkg::*;
#(
  parameter int                 NSLV     = 4,
  parameter int                 AW       = 32,
  parameter int                 DW       = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [NSLV*AW-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int                 TIMEOUT  = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  output logic                 o_wb_stall,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  output logic [DW-1:0]        o_wb_data,
  output logic [NSLV-1:0]      o_s_cyc,
  output logic [NSLV-1:0]      o_s_stb,
  output logic                 o_s_we,
  output logic [AW-1:0]        o_s_addr,
  output logic [DW-1:0]        o_s_data,
  output logic [DW/8-1:0]      o_s_sel,
  input  logic [NSLV-1:0]      i_s_stall,
  input  logic [NSLV-1:0]      i_s_ack,
  input  logic [NSLV*DW-1:0]   i_s_data,
  output logic [AW-1:0]        o_err_addr,
  output logic                 o_err_valid,
  input  logic                 i_err_clr
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  wb_state_e       state_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] sel_q;
  logic            we_q;
  logic [IW-1:0]   idx_q;
  logic [NSLV-1:0] s_cyc_q;
  logic [NSLV-1:0] s_stb_q;
  logic            ack_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;
  logic [TW-1:0]   tmo_q;
  logic [AW-1:0]   err_addr_q;
  logic            err_valid_q;

  logic            dec_hit;
  logic [IW-1:0]   dec_idx;
  logic [NSLV-1:0] dec_onehot;
  logic            sel_stall;
  logic            sel_ack;
  logic [DW-1:0]   sel_rdata;
  logic            tmo_hit;

  wb_slave_decoder_n_addr_decode #(
    .NSLV     (NSLV),
    .AW       (AW),
    .IW       (IW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr_i (i_wb_addr),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign dec_onehot = NSLV'(1) << dec_idx;

  // Only the latched slave's handshake is observed; others are ignored
  assign sel_stall = i_s_stall[idx_q];
  assign sel_ack   = i_s_ack[idx_q];
  assign sel_rdata = i_s_data[int'(idx_q)*DW +: DW];

  // Down-counter loaded with TIMEOUT on entry to REQ; terminal count is 1 so
  // the error fires after exactly TIMEOUT REQ/WAIT cycles. TIMEOUT=0 disables.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TW'(1));

  // Transfer FSM with latched request, response, timeout and error capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      s_cyc_q     <= '0;
      s_stb_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      tmo_q       <= '0;
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      // A set later in this block overrides the clear
      if (i_err_clr) err_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            addr_q  <= i_wb_addr;
            wdata_q <= i_wb_data;
            sel_q   <= i_wb_sel;
            we_q    <= i_wb_we;
            idx_q   <= dec_idx;
            if (dec_hit) begin
              state_q <= ST_REQ;
              s_cyc_q <= dec_onehot;
              s_stb_q <= dec_onehot;
              tmo_q   <= TW'(TIMEOUT);
            end else begin
              state_q     <= ST_ERR;
              err_q       <= 1'b1;
              err_addr_q  <= i_wb_addr;
              err_valid_q <= 1'b1;
            end
          end
        end

        ST_REQ, ST_WAIT: begin
          tmo_q <= tmo_q - TW'(1);
          if (!i_wb_cyc) begin
            state_q <= ST_IDLE;
            s_cyc_q <= '0;
            s_stb_q <= '0;
          end else if (sel_ack) begin
            state_q <= ST_IDLE;
            s_cyc_q <= '0;
            s_stb_q <= '0;
            ack_q   <= 1'b1;
            rdata_q <= sel_rdata;
          end else if (tmo_hit) begin
            state_q     <= ST_ERR;
            s_cyc_q     <= '0;
            s_stb_q     <= '0;
            err_q       <= 1'b1;
            err_addr_q  <= addr_q;
            err_valid_q <= 1'b1;
          end else if ((state_q == ST_REQ) && !sel_stall) begin
            state_q <= ST_WAIT;
            s_stb_q <= '0;
          end
        end

        ST_ERR: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_wb_stall  = (state_q != ST_IDLE);
  assign o_wb_ack    = ack_q;
  assign o_wb_err    = err_q;
  assign o_wb_data   = rdata_q;
  // Master abort must reach the slaves in the same cycle
  assign o_s_cyc     = s_cyc_q & {NSLV{i_wb_cyc}};
  assign o_s_stb     = s_stb_q & {NSLV{i_wb_cyc}};
  assign o_s_we      = we_q;
  assign o_s_addr    = addr_q;
  assign o_s_data    = wdata_q;
  assign o_s_sel     = sel_q;
  assign o_err_addr  = err_addr_q;
  assign o_err_valid = err_valid_q;

endmodule

// File: tb/tb_wb_slave_decoder_n.sv
// Directed bench for wb_slave_decoder_n with the default 4-slave map, plus a
// second instance whose slave1 window overlaps slave0 to exercise priority.
module tb_wb_slave_decoder_n;

  logic         clk;
  logic         rst;
  logic         wb_cyc, wb_stb, wb_we;
  logic [31:0]  wb_addr, wb_wdata;
  logic [3:0]   wb_sel;
  logic         err_clr;
  logic [3:0]   s_stall, s_ack;
  logic [127:0] s_data;

  logic         o_wb_stall, o_wb_ack, o_wb_err;
  logic [31:0]  o_wb_data;
  logic [3:0]   o_s_cyc, o_s_stb;
  logic         o_s_we;
  logic [31:0]  o_s_addr, o_s_data;
  logic [3:0]   o_s_sel;
  logic [31:0]  o_err_addr;
  logic         o_err_valid;

  logic         v_wb_stall, v_wb_ack, v_wb_err;
  logic [31:0]  v_wb_data;
  logic [3:0]   v_s_cyc, v_s_stb;
  logic         v_s_we;
  logic [31:0]  v_s_addr, v_s_data;
  logic [3:0]   v_s_sel;
  logic [31:0]  v_err_addr;
  logic         v_err_valid;

  localparam logic [127:0] DATA_BG = {32'h3333_A003, 32'h2222_A002, 32'h1111_A001, 32'h0000_A000};

  wb_slave_decoder_n dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_data(o_wb_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_addr(o_s_addr),
    .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_data(s_data),
    .o_err_addr(o_err_addr), .o_err_valid(o_err_valid), .i_err_clr(err_clr)
  );

  wb_slave_decoder_n #(
    .SLV_BASE({32'h4000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000})
  ) u_ovl (
    .i_clk(clk), .i_rst(rst),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
    .i_wb_addr(wb_addr), .i_wb_data(wb_wdata), .i_wb_sel(wb_sel),
    .o_wb_stall(v_wb_stall), .o_wb_ack(v_wb_ack), .o_wb_err(v_wb_err), .o_wb_data(v_wb_data),
    .o_s_cyc(v_s_cyc), .o_s_stb(v_s_stb), .o_s_we(v_s_we), .o_s_addr(v_s_addr),
    .o_s_data(v_s_data), .o_s_sel(v_s_sel),
    .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_data(s_data),
    .o_err_addr(v_err_addr), .o_err_valid(v_err_valid), .i_err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          slv;
    int          stall_n;
    logic [31:0] rdata;
    logic        exp_err;
    logic [3:0]  exp_cyc;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_stb;
  } vec_t;

  vec_t vecs[10];

  int n_cmp = 0;
  int n_miss = 0;

  // Bench slave model: stalls the target slave stall_left cycles, acks in WAIT
  logic man = 1'b0;
  logic rsp_en = 1'b0;
  int   rsp_slv = 0;
  int   stall_left = 0;
  logic [3:0] ovl_cyc_k1;

  always @(posedge clk) begin
    #2;
    if (!man) begin
      s_stall = '0;
      s_ack   = '0;
      if (rsp_en) begin
        if (o_s_stb[rsp_slv] && stall_left > 0) begin
          s_stall[rsp_slv] = 1'b1;
          stall_left--;
        end else if (o_s_cyc[rsp_slv] && !o_s_stb[rsp_slv]) begin
          s_ack[rsp_slv] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int k, lat, stb_cnt;
    logic got, ack_s, err_s, other, both;
    logic [31:0] dat, sa, sd;
    logic [3:0] ss;
    logic swe;
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = v.we;
    wb_addr = v.addr; wb_wdata = v.wdata; wb_sel = v.sel;
    s_data = DATA_BG;
    s_data[v.slv*32 +: 32] = v.rdata;
    rsp_slv = v.slv; stall_left = v.stall_n; rsp_en = 1'b1;
    @(posedge clk); #1;
    wb_stb = 1'b0;
    k = 1; lat = 0; stb_cnt = 0; got = 0; ack_s = 0; err_s = 0;
    other = 0; both = 0; dat = '0; sa = '0; sd = '0; ss = '0; swe = 0;
    while (!got && k < 400) begin
      @(negedge clk);
      if (k == 1) begin
        sa = o_s_addr; sd = o_s_data; ss = o_s_sel; swe = o_s_we;
        ovl_cyc_k1 = v_s_cyc;
      end
      if (v.exp_cyc != 4'b0 && o_s_stb == v.exp_cyc) stb_cnt++;
      if (o_s_cyc != 4'b0 && o_s_cyc != v.exp_cyc) other = 1;
      if (o_wb_ack && o_wb_err) both = 1;
      if (o_wb_ack || o_wb_err) begin
        got = 1; lat = k; ack_s = o_wb_ack; err_s = o_wb_err; dat = o_wb_data;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    @(posedge clk); #1;
    wb_cyc = 1'b0;
    rsp_en = 1'b0;
    chk({nm, "_resp"}, {62'b0, ack_s, err_s}, v.exp_err ? 64'd1 : 64'd2);
    chk({nm, "_lat"}, lat, v.exp_lat);
    chk({nm, "_data"}, dat, v.exp_data);
    chk({nm, "_stb_cycles"}, stb_cnt, v.exp_stb);
    chk({nm, "_wrong_cyc"}, other, 0);
    chk({nm, "_ack_err_both"}, both, 0);
    if (!v.exp_err) begin
      chk({nm, "_s_addr"}, sa, v.addr);
      chk({nm, "_s_wr"}, {sd, ss, swe}, {v.wdata, v.sel, v.we});
    end
  endtask

  initial begin : main
    int k, cnt;
    logic got, ack_seen;
    logic [3:0] cyc_at;
    logic [31:0] ea;

    //          addr          we    wdata         sel    slv st  rdata         err   cyc      exp_data      lat stb
    vecs[0] = '{32'h0001_0010, 1'b0, 32'h0,        4'hF,  1, 2, 32'hDEAD_BEEF, 1'b0, 4'b0010, 32'hDEAD_BEEF, 5, 3};
    vecs[1] = '{32'h8000_0004, 1'b1, 32'h1234_5678, 4'h3, 2, 0, 32'h0,        1'b0, 4'b0100, 32'h0,        3, 1};
    vecs[2] = '{32'h2000_0000, 1'b0, 32'h0,        4'hF,  0, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0};
    vecs[3] = '{32'h4000_0010, 1'b0, 32'h0,        4'hF,  3, 1, 32'hCAFE_0003, 1'b0, 4'b1000, 32'hCAFE_0003, 4, 2};
    vecs[4] = '{32'h4080_0000, 1'b1, 32'h55AA_55AA, 4'hF, 3, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0};
    vecs[5] = '{32'h407F_FFFC, 1'b0, 32'h0,        4'hF,  3, 0, 32'h0BAD_F00D, 1'b0, 4'b1000, 32'h0BAD_F00D, 3, 1};
    vecs[6] = '{32'h0002_0000, 1'b0, 32'h0,        4'hF,  1, 0, 32'h0,        1'b1, 4'b0000, 32'h0,        1, 0};
    vecs[7] = '{32'h80FF_FFFC, 1'b1, 32'hA5A5_0007, 4'hC, 2, 3, 32'h0,        1'b0, 4'b0100, 32'h0,        6, 4};
    vecs[8] = '{32'h0000_FFFC, 1'b0, 32'h0,        4'hF,  0, 0, 32'h7777_0000, 1'b0, 4'b0001, 32'h7777_0000, 3, 1};
    vecs[9] = '{32'h0000_0100, 1'b0, 32'h0,        4'hF,  0, 1, 32'h0000_1111, 1'b0, 4'b0001, 32'h0000_1111, 4, 2};

    rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = '0; wb_wdata = '0;
    wb_sel = '0; err_clr = 0; s_stall = '0; s_ack = '0; s_data = DATA_BG;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {o_wb_stall, o_wb_ack, o_wb_err, o_err_valid, o_s_we}, 5'b0);
    chk("rst_s_cyc_stb", {o_s_cyc, o_s_stb}, 8'b0);
    chk("rst_s_addr", o_s_addr, 0);
    chk("rst_s_data_sel", {o_s_data, o_s_sel}, 0);
    chk("rst_wb_data", o_wb_data, 0);
    chk("rst_err_addr", o_err_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Overlapping windows: 0x100 matches slave0 and slave1, slave0 wins
    chk("ovl_priority", ovl_cyc_k1, 4'b0001);

    // Error capture, clear, and set winning over a simultaneous clear
    @(negedge clk);
    chk("errcap_addr", o_err_addr, 32'h0002_0000);
    chk("errcap_valid", o_err_valid, 1);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk);
    chk("errclr_valid", o_err_valid, 0);
    chk("errclr_addr_kept", o_err_addr, 32'h0002_0000);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h2000_0000; err_clr = 1'b1;
    @(negedge clk);
    chk("unmapped_t0_stall", o_wb_stall, 0);
    @(posedge clk); #1;
    wb_stb = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    chk("setwins_err_pulse", {o_wb_err, o_wb_ack, o_s_cyc}, 6'b100000);
    chk("setwins_valid", o_err_valid, 1);
    chk("setwins_addr", o_err_addr, 32'h2000_0000);
    @(posedge clk); #1; wb_cyc = 1'b0;

    // Slave3 never answers: timeout after 255 REQ/WAIT cycles
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h4000_0000;
    @(posedge clk); #1;
    wb_stb = 1'b0;
    k = 0; cnt = 0; got = 0; ack_seen = 0; cyc_at = '0; ea = '0;
    while (!got && k < 400) begin
      @(negedge clk);
      if (o_wb_err || o_wb_ack) begin
        got = 1; ack_seen = o_wb_ack; cyc_at = o_s_cyc; ea = o_err_addr;
      end else begin
        if (o_s_cyc[3]) cnt++;
        @(posedge clk); #1;
        k++;
      end
    end
    chk("tmo_err", {got, ack_seen}, 2'b10);
    chk("tmo_cycles", cnt, 255);
    chk("tmo_cyc_dropped", cyc_at, 0);
    chk("tmo_err_addr", ea, 32'h4000_0000);
    @(posedge clk); #1; wb_cyc = 1'b0;
    run_vec(vecs[0], "post_tmo");

    // Master abort in WAIT, then a late ack from slave0
    man = 1'b1; s_stall = '0; s_ack = '0;
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h0000_0040;
    @(posedge clk); #1; wb_stb = 1'b0;
    @(negedge clk);
    chk("abort_req_cyc", o_s_cyc, 4'b0001);
    @(posedge clk); #1; wb_cyc = 1'b0;
    @(negedge clk);
    chk("abort_gated", {o_s_cyc, o_s_stb}, 8'b0);
    chk("abort_stall_wait", o_wb_stall, 1);
    @(posedge clk); #1; s_ack = 4'b0001;
    @(negedge clk);
    chk("abort_idle", {o_wb_stall, o_wb_ack, o_wb_err}, 3'b000);
    @(posedge clk); #1; s_ack = 4'b0000;
    @(negedge clk);
    chk("abort_late_ack", {o_wb_ack, o_wb_err}, 2'b00);

    // Reset while slave1 is stalling in REQ
    @(posedge clk); #1;
    s_stall = 4'b0010;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_addr = 32'h0001_0000;
    @(posedge clk); #1; wb_stb = 1'b0;
    @(negedge clk);
    chk("rstreq_stb", o_s_stb, 4'b0010);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rstreq_s_cyc_stb", {o_s_cyc, o_s_stb}, 8'b0);
    chk("rstreq_flags", {o_wb_stall, o_wb_ack, o_wb_err, o_err_valid}, 4'b0);
    chk("rstreq_s_addr", o_s_addr, 0);
    @(posedge clk); #1; wb_cyc = 1'b0;
    @(negedge clk);
    chk("rstreq_no_resp", {o_wb_ack, o_wb_err}, 2'b00);
    s_stall = '0; man = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
